ncsp_mash_gen: RTL and testbench

- Parametrised MASH 1-1-1 delta-sigma modulator built from cascaded error-feedback accumulators, with a noise-cancellation network and an integer-part adder.
- Drives the fractional-N divider control word from a fractional input and an integer input.
- Adds four features: generic accumulator width, runtime-selectable order (0..3), seed load with a synchronous load strobe, and optional LFSR LSB dither.
- Output is a saturated divider word plus a raw signed MASH sequence.

---
 rtl/ncsp_mash_gen.sv | 190 +++++++++++++++++++
 tb/tb_ncsp_mash_gen.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncsp_mash_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ncsp_mash_gen
//  Description : MASH 1-1-1 delta-sigma modulator for a fractional-N divider.
//                Three cascaded error-feedback accumulators feed a
//                noise-cancellation network. The cancelled sequence is added to
//                the integer word and saturated. The order (0..3) can be
//                selected at runtime, stage 1 can be seeded, and an optional
//                LFSR LSB dither can be added to the stage-1 input.
//  Revision    : 1.0 - initial release
// ============================================================================
module ncsp_mash_gen #(
    parameter int unsigned P_ACC_WIDTH = 16,
    parameter int unsigned P_INT_WIDTH = 8,
    parameter logic [15:0] P_LFSR_SEED = 16'hACE1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_load,
    input  logic [1:0]             i_order,
    input  logic                   i_dither_en,
    input  logic [P_ACC_WIDTH-1:0] i_seed,
    input  logic [P_ACC_WIDTH-1:0] i_frac,
    input  logic [P_INT_WIDTH-1:0] i_int,
    output logic [3:0]             o_y,
    output logic [P_INT_WIDTH-1:0] o_div,
    output logic                   o_valid,
    output logic                   o_sat
);

    localparam int unsigned W  = P_ACC_WIDTH;
    localparam int unsigned IW = P_INT_WIDTH;

    // Accumulator, carry-history, configuration and output state
    logic [W-1:0]  acc1_q, acc1_d;
    logic [W-1:0]  acc2_q, acc2_d;
    logic [W-1:0]  acc3_q, acc3_d;
    logic          c2_dly_q, c2_dly_d;
    logic          c3_dly_q, c3_dly_d;
    logic          c3_dly2_q, c3_dly2_d;
    logic [1:0]    order_q, order_d;
    logic          dith_q, dith_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [3:0]    y_q, y_d;
    logic [IW-1:0] div_q, div_d;
    logic          valid_q, valid_d;
    logic          sat_q, sat_d;

    // Datapath wires
    logic          w_step;
    logic          w_st1, w_st2, w_st3;
    logic          w_dbit;
    logic [W:0]    w_s1, w_s2, w_s3;
    logic          w_c1, w_c2, w_c3;
    logic [3:0]    w_y_raw;
    logic [3:0]    w_y;
    logic [IW+1:0] w_sum;
    logic          w_neg, w_over;
    logic [IW-1:0] w_div;
    logic          w_lfsr_fb;

    // Load takes priority, so an enable during a load cycle is not a step
    assign w_step = i_en & ~i_load;

    // A stage is active when the latched order reaches it
    assign w_st1 = (order_q != 2'd0);
    assign w_st2 = order_q[1];
    assign w_st3 = &order_q;

    // Dither adds the LFSR LSB as an extra LSB on the stage-1 input
    assign w_dbit = dith_q & lfsr_q[0];

    // Cascaded accumulators; each stage integrates the previous stage's residue
    assign w_s1 = {1'b0, acc1_q} + {1'b0, i_frac} + {{W{1'b0}}, w_dbit};
    assign w_s2 = {1'b0, acc2_q} + {1'b0, w_s1[W-1:0]};
    assign w_s3 = {1'b0, acc3_q} + {1'b0, w_s2[W-1:0]};

    // Carries of inactive stages are forced to zero so they cancel out of y
    assign w_c1 = w_st1 & w_s1[W];
    assign w_c2 = w_st2 & w_s2[W];
    assign w_c3 = w_st3 & w_s3[W];

    // Noise cancellation: c1 + (1-z^-1)c2 + (1-z^-1)^2 c3. The result range
    // -3..+4 fits in 4 bits, so modulo-16 arithmetic gives the exact value.
    assign w_y_raw = {3'b000, w_c1}
                   + {3'b000, w_c2}
                   - {3'b000, c2_dly_q}
                   + {3'b000, w_c3}
                   - {2'b00, c3_dly_q, 1'b0}
                   + {3'b000, c3_dly2_q};
    assign w_y     = w_st1 ? w_y_raw : 4'd0;

    // Integer plus sign-extended y, with two guard bits to detect the clamp
    assign w_sum  = {2'b00, i_int} + {{(IW-2){w_y[3]}}, w_y};
    assign w_neg  = w_sum[IW+1];
    assign w_over = ~w_sum[IW+1] & w_sum[IW];
    assign w_div  = w_neg ? {IW{1'b0}} : (w_over ? {IW{1'b1}} : w_sum[IW-1:0]);

    // Fibonacci LFSR using taps 16,14,13,11 and shifting toward bit 0
    assign w_lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // Next-state selection: load, then step, then hold
    always_comb begin
        acc1_d    = acc1_q;
        acc2_d    = acc2_q;
        acc3_d    = acc3_q;
        c2_dly_d  = c2_dly_q;
        c3_dly_d  = c3_dly_q;
        c3_dly2_d = c3_dly2_q;
        order_d   = order_q;
        dith_d    = dith_q;
        lfsr_d    = lfsr_q;
        y_d       = y_q;
        div_d     = div_q;
        valid_d   = 1'b0;
        sat_d     = sat_q;
        if (i_load) begin
            acc1_d    = i_seed;
            acc2_d    = {W{1'b0}};
            acc3_d    = {W{1'b0}};
            c2_dly_d  = 1'b0;
            c3_dly_d  = 1'b0;
            c3_dly2_d = 1'b0;
            order_d   = i_order;
            dith_d    = i_dither_en;
            lfsr_d    = P_LFSR_SEED;
        end else if (w_step) begin
            if (w_st1) begin
                acc1_d = w_s1[W-1:0];
            end
            if (w_st2) begin
                acc2_d = w_s2[W-1:0];
            end
            if (w_st3) begin
                acc3_d = w_s3[W-1:0];
            end
            c2_dly_d  = w_c2;
            c3_dly2_d = c3_dly_q;
            c3_dly_d  = w_c3;
            if (dith_q) begin
                lfsr_d = {w_lfsr_fb, lfsr_q[15:1]};
            end
            y_d     = w_y;
            div_d   = w_div;
            sat_d   = w_neg | w_over;
            valid_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc1_q    <= {W{1'b0}};
            acc2_q    <= {W{1'b0}};
            acc3_q    <= {W{1'b0}};
            c2_dly_q  <= 1'b0;
            c3_dly_q  <= 1'b0;
            c3_dly2_q <= 1'b0;
            order_q   <= 2'd0;
            dith_q    <= 1'b0;
            lfsr_q    <= P_LFSR_SEED;
            y_q       <= 4'd0;
            div_q     <= {IW{1'b0}};
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            acc1_q    <= acc1_d;
            acc2_q    <= acc2_d;
            acc3_q    <= acc3_d;
            c2_dly_q  <= c2_dly_d;
            c3_dly_q  <= c3_dly_d;
            c3_dly2_q <= c3_dly2_d;
            order_q   <= order_d;
            dith_q    <= dith_d;
            lfsr_q    <= lfsr_d;
            y_q       <= y_d;
            div_q     <= div_d;
            valid_q   <= valid_d;
            sat_q     <= sat_d;
        end
    end

    assign o_y     = y_q;
    assign o_div   = div_q;
    assign o_valid = valid_q;
    assign o_sat   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_ncsp_mash_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ncsp_mash_gen
//  Description : Self-checking bench for ncsp_mash_gen against an arithmetic
//                model of the MASH 1-1-1 carry/cancellation equations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ncsp_mash_gen;

    localparam int W  = 16;
    localparam int IW = 8;
    localparam logic [15:0] SEED_LFSR = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, load, dith;
    logic [1:0]    order;
    logic [W-1:0]  seed, frac;
    logic [IW-1:0] ival;
    logic [3:0]    o_y;
    logic [IW-1:0] o_div;
    logic          o_valid, o_sat;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    longint unsigned m_acc [3];
    int              m_p2, m_p3, m_pp3;
    int              m_order;
    bit              m_dith;
    bit [15:0]       m_lfsr;
    int              last_y;
    bit [3:0]        e_y;
    bit [IW-1:0]     e_div;
    bit              e_valid, e_sat;

    always #5 clk = ~clk;

    ncsp_mash_gen #(
        .P_ACC_WIDTH (W),
        .P_INT_WIDTH (IW),
        .P_LFSR_SEED (SEED_LFSR)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_load      (load),
        .i_order     (order),
        .i_dither_en (dith),
        .i_seed      (seed),
        .i_frac      (frac),
        .i_int       (ival),
        .o_y         (o_y),
        .o_div       (o_div),
        .o_valid     (o_valid),
        .o_sat       (o_sat)
    );

    function automatic bit [15:0] lfsr_adv(input bit [15:0] l);
        bit fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    task automatic model_reset();
        m_acc   = '{0, 0, 0};
        m_p2    = 0; m_p3 = 0; m_pp3 = 0;
        m_order = 0; m_dith = 0; m_lfsr = SEED_LFSR;
        e_y = 0; e_div = 0; e_valid = 0; e_sat = 0; last_y = 0;
    endtask

    task automatic model_load(input int s, input int o, input bit d);
        m_acc   = '{longint'(s), 0, 0};
        m_p2    = 0; m_p3 = 0; m_pp3 = 0;
        m_order = o; m_dith = d; m_lfsr = SEED_LFSR;
        e_valid = 0;
    endtask

    task automatic model_step(input int f, input int iv);
        longint unsigned md, s;
        int c1, c2, c3, y, t, d;
        md = longint'(1) << W;
        c1 = 0; c2 = 0; c3 = 0; y = 0;
        d  = (m_dith && m_lfsr[0]) ? 1 : 0;
        if (m_order >= 1) begin
            s = m_acc[0] + longint'(f) + longint'(d);
            c1 = (s >= md) ? 1 : 0;
            m_acc[0] = s % md;
        end
        if (m_order >= 2) begin
            s = m_acc[1] + m_acc[0];
            c2 = (s >= md) ? 1 : 0;
            m_acc[1] = s % md;
        end
        if (m_order == 3) begin
            s = m_acc[2] + m_acc[1];
            c3 = (s >= md) ? 1 : 0;
            m_acc[2] = s % md;
        end
        if (m_order != 0) y = c1 + (c2 - m_p2) + (c3 - 2 * m_p3 + m_pp3);
        m_p2 = c2; m_pp3 = m_p3; m_p3 = c3;
        if (m_dith) m_lfsr = lfsr_adv(m_lfsr);
        t = iv + y;
        if (t < 0) begin
            e_div = 0; e_sat = 1;
        end else if (t > (1 << IW) - 1) begin
            e_div = '1; e_sat = 1;
        end else begin
            e_div = IW'(t); e_sat = 0;
        end
        e_y = 4'(y); last_y = y; e_valid = 1;
    endtask

    // Stimulus drivers: change inputs at negedge, leave outputs settled 1 after posedge
    task automatic drive_step(input logic [W-1:0] f, input logic [IW-1:0] iv);
        @(negedge clk);
        load = 0; en = 1; frac = f; ival = iv;
        model_step(int'(f), int'(iv));
        @(posedge clk); #1;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        load = 0; en = 0; frac = W'($urandom); ival = IW'($urandom);
        e_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic drive_load(input logic [W-1:0] s, input logic [1:0] o, input bit d, input bit with_en);
        @(negedge clk);
        load = 1; en = with_en; seed = s; order = o; dith = d;
        frac = W'($urandom); ival = IW'($urandom);
        model_load(int'(s), int'(o), d);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; load = 0; order = 0; dith = 0; seed = 0; frac = 0; ival = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1;
        #1;
        n_cmp++;
        if ({o_valid, o_y, o_div, o_sat} !== {e_valid, e_y, e_div, e_sat}) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b y=%h div=%0d sat=%b, want all zero", o_valid, o_y, o_div, o_sat);
        end
    endtask

    task automatic test_order1();
        drive_load(16'h0000, 2'd1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive_step(16'h8000, 8'd10);
            n_cmp++;
            if ({o_valid, o_y, o_div, o_sat} !== {1'b1, 4'(k % 2), 8'(10 + k % 2), 1'b0}) begin
                n_bad++;
                $display("FAIL order1_seq step %0d: got v=%b y=%0d div=%0d sat=%b, want v=1 y=%0d div=%0d sat=0",
                         k, o_valid, $signed(o_y), o_div, o_sat, k % 2, 10 + k % 2);
            end
        end
        drive_idle();
        n_cmp++;
        if ({o_valid, o_y, o_div, o_sat} !== {1'b0, 4'd1, 8'd11, 1'b0}) begin
            n_bad++;
            $display("FAIL order1_hold: got v=%b y=%0d div=%0d sat=%b, want v=0 y=1 div=11 sat=0",
                     o_valid, $signed(o_y), o_div, o_sat);
        end
    endtask

    task automatic test_order3_mean();
        int sum, bad_range, bad_model, sat_seen;
        sum = 0; bad_range = 0; bad_model = 0; sat_seen = 0;
        drive_load(16'h0000, 2'd3, 1'b0, 1'b0);
        for (int k = 0; k < 4096; k++) begin
            drive_step(16'h4000, 8'd10);
            sum += int'($signed(o_y));
            if ($signed(o_y) < -3 || $signed(o_y) > 4) bad_range++;
            if (o_sat) sat_seen++;
            if ({o_valid, o_y, o_div, o_sat} !== {e_valid, e_y, e_div, e_sat}) begin
                if (bad_model < 5)
                    $display("FAIL order3_model step %0d: got v=%b y=%0d div=%0d sat=%b, want v=%b y=%0d div=%0d sat=%b",
                             k, o_valid, $signed(o_y), o_div, o_sat, e_valid, $signed(e_y), e_div, e_sat);
                bad_model++;
            end
        end
        n_cmp++;
        if (bad_model != 0) begin
            n_bad++;
            $display("FAIL order3_model_total: got %0d differing steps, want 0", bad_model);
        end
        n_cmp++;
        if (bad_range != 0) begin
            n_bad++;
            $display("FAIL order3_range: got %0d outputs outside -3..4, want 0", bad_range);
        end
        n_cmp++;
        if (sum < 1021 || sum > 1027) begin
            n_bad++;
            $display("FAIL order3_mean: got sum %0d, want 1024 +/- 3", sum);
        end
        n_cmp++;
        if (sat_seen != 0) begin
            n_bad++;
            $display("FAIL order3_nosat: got %0d saturated outputs, want 0", sat_seen);
        end
    endtask

    task automatic test_order2_sat();
        int neg_seen;
        logic [W-1:0] f;
        neg_seen = 0;
        drive_load(16'hFFF0, 2'd2, 1'b0, 1'b0);
        for (int k = 0; k < 400; k++) begin
            f = (k < 100) ? W'(1) : W'($urandom);
            drive_step(f, 8'd0);
            n_cmp++;
            if ({o_valid, o_y, o_div, o_sat} !== {e_valid, e_y, e_div, e_sat}) begin
                n_bad++;
                $display("FAIL order2_model step %0d: got y=%0d div=%0d sat=%b, want y=%0d div=%0d sat=%b",
                         k, $signed(o_y), o_div, o_sat, $signed(e_y), e_div, e_sat);
            end
            if (o_y === 4'hF) begin
                neg_seen++;
                n_cmp++;
                if (o_div !== 8'd0 || o_sat !== 1'b1) begin
                    n_bad++;
                    $display("FAIL order2_clamp step %0d: got div=%0d sat=%b, want div=0 sat=1", k, o_div, o_sat);
                end
            end else begin
                n_cmp++;
                if (o_sat !== 1'b0) begin
                    n_bad++;
                    $display("FAIL order2_nosat step %0d: got sat=%b y=%0d, want sat=0", k, o_sat, $signed(o_y));
                end
            end
        end
        n_cmp++;
        if (neg_seen == 0) begin
            n_bad++;
            $display("FAIL order2_neg_seen: got 0 outputs of -1, want at least 1");
        end
    endtask

    task automatic test_order0();
        logic [IW-1:0] iv;
        drive_load(W'($urandom), 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
                order = 2'd3;
                dith  = 1'b1;
            end
            iv = IW'($urandom);
            drive_step(W'($urandom), iv);
            n_cmp++;
            if ({o_valid, o_y, o_div, o_sat} !== {1'b1, 4'd0, iv, 1'b0}) begin
                n_bad++;
                $display("FAIL order0 step %0d: got v=%b y=%0d div=%0d sat=%b, want v=1 y=0 div=%0d sat=0",
                         k, o_valid, $signed(o_y), o_div, o_sat, iv);
            end
        end
        drive_load(16'h0000, 2'd3, 1'b0, 1'b0);
        for (int k = 0; k < 60; k++) begin
            drive_step(W'($urandom), IW'($urandom_range(0, 255)));
            n_cmp++;
            if ({o_valid, o_y, o_div, o_sat} !== {e_valid, e_y, e_div, e_sat}) begin
                n_bad++;
                $display("FAIL order0_to_3 step %0d: got y=%0d div=%0d sat=%b, want y=%0d div=%0d sat=%b",
                         k, $signed(o_y), o_div, o_sat, $signed(e_y), e_div, e_sat);
            end
        end
    endtask

    task automatic test_dither();
        logic [3:0] rec [1000];
        int nz, diff;
        logic [W-1:0] s;
        nz = 0; diff = 0;
        s = 16'hFFC0;
        drive_load(s, 2'd1, 1'b1, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            drive_step(16'h0000, 8'd50);
            rec[k] = o_y;
            if (o_y !== 4'd0) nz++;
            n_cmp++;
            if ({o_valid, o_y, o_div, o_sat} !== {e_valid, e_y, e_div, e_sat}) begin
                n_bad++;
                $display("FAIL dither_model step %0d: got y=%0d div=%0d, want y=%0d div=%0d",
                         k, $signed(o_y), o_div, $signed(e_y), e_div);
            end
        end
        n_cmp++;
        if (nz == 0) begin
            n_bad++;
            $display("FAIL dither_nonzero: got 0 nonzero outputs, want at least 1");
        end
        drive_load(s, 2'd1, 1'b1, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            drive_step(16'h0000, 8'd50);
            if (o_y !== rec[k]) diff++;
        end
        n_cmp++;
        if (diff != 0) begin
            n_bad++;
            $display("FAIL dither_repeat: got %0d differing outputs after reload, want 0", diff);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s;
        drive_load(W'($urandom), 2'd3, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) drive_step(W'($urandom), 8'd100);
        @(negedge clk);
        en = 1; load = 0; frac = W'($urandom); ival = 8'd100;
        #2 rst_n = 0;
        #1;
        model_reset();
        n_cmp++;
        if ({o_valid, o_y, o_div, o_sat} !== {1'b0, 4'd0, 8'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_async: got v=%b y=%0d div=%0d sat=%b, want all zero",
                     o_valid, $signed(o_y), o_div, o_sat);
        end
        @(negedge clk);
        en = 0; rst_n = 1;
        s = W'($urandom);
        drive_load(s, 2'd2, 1'b0, 1'b1);
        n_cmp++;
        if ({o_valid, o_y, o_div, o_sat} !== {1'b0, 4'd0, 8'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL load_with_en: got v=%b y=%0d div=%0d sat=%b, want v=0 y=0 div=0 sat=0",
                     o_valid, $signed(o_y), o_div, o_sat);
        end
        for (int k = 0; k < 40; k++) begin
            drive_step(W'($urandom), IW'($urandom_range(0, 3)));
            n_cmp++;
            if ({o_valid, o_y, o_div, o_sat} !== {e_valid, e_y, e_div, e_sat}) begin
                n_bad++;
                $display("FAIL after_load_en step %0d: got y=%0d div=%0d sat=%b, want y=%0d div=%0d sat=%b",
                         k, $signed(o_y), o_div, o_sat, $signed(e_y), e_div, e_sat);
            end
        end
    endtask

    task automatic test_random();
        int r;
        logic [IW-1:0] iv;
        for (int blk = 0; blk < 8; blk++) begin
            drive_load(W'($urandom), 2'($urandom), 1'($urandom), 1'b0);
            for (int k = 0; k < 150; k++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    drive_idle();
                end else begin
                    iv = (r == 1) ? 8'd0 : ((r == 2) ? 8'd255 : ((r == 3) ? 8'd254 : IW'($urandom)));
                    drive_step(W'($urandom), iv);
                end
                n_cmp++;
                if ({o_valid, o_y, o_div, o_sat} !== {e_valid, e_y, e_div, e_sat}) begin
                    n_bad++;
                    $display("FAIL random blk %0d step %0d: got v=%b y=%0d div=%0d sat=%b, want v=%b y=%0d div=%0d sat=%b",
                             blk, k, o_valid, $signed(o_y), o_div, o_sat, e_valid, $signed(e_y), e_div, e_sat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_order1();
        test_order3_mean();
        test_order2_sat();
        test_order0();
        test_dither();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
